regfile_harness: RTL and testbench

- Parametrised successor to the single-cycle register-file test top.
- An instruction word carries a write enable, a write address and two read addresses, which drive an NREG x XLEN register file.
- Adds a valid/ready instruction handshake, a retired-instruction counter, write-to-read bypass and a sequential register-dump mode for the Verilator bench.
- Sits at the top of the npc test tree; the bench drives it directly.

---
 rtl/regfile_harness.sv | 153 +++++++++++++++
 tb/tb_regfile_harness.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_harness.sv
`default_nettype none
// ============================================================================
// Module   : regfile_harness
// Brief    : NREG x XLEN register file driven by an instruction word with a
//            valid/ready handshake, write-to-read bypass, a retired
//            instruction counter and a sequential register-dump mode.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module regfile_harness #(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int CNT_W = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [3*AW:0]     inst,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   rs1,
  output logic [XLEN-1:0]   rs2,
  output logic [CNT_W-1:0]  cnt,
  input  logic              dump_req,
  output logic              busy,
  output logic              dump_valid,
  output logic [AW-1:0]     dump_addr,
  output logic [XLEN-1:0]   dump_data,
  output logic              dump_last
);

  localparam logic [0:0]       c_idle     = 1'b0;
  localparam logic [0:0]       c_dump     = 1'b1;
  localparam logic [AW-1:0]    c_last_idx = AW'(NREG - 1);
  localparam logic [AW-1:0]    c_idx_one  = AW'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  // Instruction field decode
  logic [AW-1:0] w_raddr1;
  logic [AW-1:0] w_raddr2;
  logic [AW-1:0] w_waddr;
  logic          w_wen;
  assign w_raddr1 = inst[AW-1:0];
  assign w_raddr2 = inst[2*AW-1:AW];
  assign w_waddr  = inst[3*AW-1:2*AW];
  assign w_wen    = inst[3*AW];

  logic [0:0]       r_state;
  logic [0:0]       w_next_state;
  logic [AW-1:0]    r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_we;

  // inst_ready is combinational on state, so acceptance is known this cycle
  assign w_accept = inst_valid && inst_ready;
  // Writes to x0 are dropped here so neither storage nor bypass sees them
  assign w_we     = w_accept && w_wen && (w_waddr != '0);

  // Read view of the file; entry 0 is a constant zero with no storage
  logic [XLEN-1:0] w_rf [NREG];
  assign w_rf[0] = '0;

  generate
    for (genvar i = 1; i < NREG; i++) begin : g_reg
      logic [XLEN-1:0] r_q;
      // One architectural register, loaded when the write targets it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_we && (w_waddr == AW'(i))) begin
          r_q <= data;
        end
      end
      assign w_rf[i] = r_q;
    end
  endgenerate

  // Combinational read ports with same-cycle bypass of the accepted write
  always_comb begin
    rs1 = w_rf[w_raddr1];
    rs2 = w_rf[w_raddr2];
    if (w_we && (w_waddr == w_raddr1)) rs1 = data;
    if (w_we && (w_waddr == w_raddr2)) rs2 = data;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end
  assign cnt = r_cnt;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; dump_req is only sampled in IDLE, so it is never queued
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (dump_req) w_next_state = c_dump;
      c_dump:  if (r_idx == c_last_idx) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Dump index: parked at 0 in IDLE so every dump starts from x0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (r_state == c_idle) begin
      r_idx <= '0;
    end else begin
      r_idx <= r_idx + c_idx_one;
    end
  end

  // FSM outputs; dump outputs are forced to zero outside DUMP
  always_comb begin
    inst_ready = 1'b0;
    busy       = 1'b0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    dump_last  = 1'b0;
    case (r_state)
      c_idle: begin
        inst_ready = 1'b1;
      end
      c_dump: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_addr  = r_idx;
        dump_data  = w_rf[r_idx];
        dump_last  = (r_idx == c_last_idx);
      end
      default: begin
        inst_ready = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_harness.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_harness
// Brief    : Directed self-checking bench for regfile_harness.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_harness;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 8;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              inst_valid;
  logic              inst_ready;
  logic [3*AW:0]     inst;
  logic [XLEN-1:0]   data;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [CNT_W-1:0]  cnt;
  logic              dump_req;
  logic              busy;
  logic              dump_valid;
  logic [AW-1:0]     dump_addr;
  logic [XLEN-1:0]   dump_data;
  logic              dump_last;

  int total = 0;
  int bad   = 0;

  regfile_harness #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .data       (data),
    .rs1        (rs1),
    .rs2        (rs2),
    .cnt        (cnt),
    .dump_req   (dump_req),
    .busy       (busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3*AW:0] mk(input logic wen, input logic [AW-1:0] wa,
                                       input logic [AW-1:0] ra2, input logic [AW-1:0] ra1);
    return {wen, wa, ra2, ra1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3*AW:0] i, input logic [XLEN-1:0] d,
                       input logic dr);
    inst_valid = v;
    inst       = i;
    data       = d;
    dump_req   = dr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, mk(1'b0, 5'd0, 5'd0, 5'd5), '0, 1'b0);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_in_reset: got %b want 0", busy); end
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL rst_dvalid_in_reset: got %b want 0", dump_valid); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", inst_ready); end
    total++; if (dump_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", dump_last); end
    total++; if (dump_addr !== 5'd0) begin bad++; $display("FAIL rst_daddr: got %0d want 0", dump_addr); end
    total++; if (dump_data !== 32'h0) begin bad++; $display("FAIL rst_ddata: got %h want 0", dump_data); end
    total++; if (cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
    total++; if (rs1 !== 32'h0) begin bad++; $display("FAIL rst_rs1: got %h want 0", rs1); end
    tick();
  endtask

  task automatic test_write_read();
    drive(1'b1, mk(1'b1, 5'd5, 5'd0, 5'd0), 32'hDEADBEEF, 1'b0);
    tick();
    drive(1'b1, mk(1'b0, 5'd0, 5'd0, 5'd5), 32'h0, 1'b0);
    @(negedge clk);
    total++; if (rs1 !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_rs1: got %h want deadbeef", rs1); end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    total++; if (cnt !== 8'd2) begin bad++; $display("FAIL wr_rd_cnt: got %0d want 2", cnt); end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, mk(1'b1, 5'd7, 5'd7, 5'd7), 32'h12345678, 1'b0);
    @(negedge clk);
    total++; if (rs1 !== 32'h12345678) begin bad++; $display("FAIL byp_rs1: got %h want 12345678", rs1); end
    total++; if (rs2 !== 32'h12345678) begin bad++; $display("FAIL byp_rs2: got %h want 12345678", rs2); end
    tick();
    drive(1'b0, mk(1'b0, 5'd0, 5'd7, 5'd7), 32'h0, 1'b0);
    @(negedge clk);
    total++; if (rs1 !== 32'h12345678) begin bad++; $display("FAIL byp_hold_rs1: got %h want 12345678", rs1); end
    total++; if (rs2 !== 32'h12345678) begin bad++; $display("FAIL byp_hold_rs2: got %h want 12345678", rs2); end
    total++; if (cnt !== 8'd3) begin bad++; $display("FAIL byp_cnt: got %0d want 3", cnt); end
    tick();
  endtask

  task automatic test_x0();
    drive(1'b1, mk(1'b1, 5'd0, 5'd0, 5'd0), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    total++; if (rs1 !== 32'h0) begin bad++; $display("FAIL x0_bypass: got %h want 0", rs1); end
    tick();
    drive(1'b0, mk(1'b0, 5'd0, 5'd0, 5'd0), 32'h0, 1'b0);
    @(negedge clk);
    total++; if (rs1 !== 32'h0) begin bad++; $display("FAIL x0_read: got %h want 0", rs1); end
    total++; if (cnt !== 8'd4) begin bad++; $display("FAIL x0_cnt: got %0d want 4", cnt); end
    tick();
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, mk(1'b0, 5'd0, 5'd0, 5'd0), 32'h0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    total++; if (cnt !== 8'd255) begin bad++; $display("FAIL cnt_255: got %0d want 255", cnt); end
    tick();
    drive(1'b1, mk(1'b0, 5'd0, 5'd0, 5'd0), 32'h0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    total++; if (cnt !== 8'd0) begin bad++; $display("FAIL cnt_wrap: got %0d want 0", cnt); end
    tick();
    drive(1'b1, mk(1'b0, 5'd0, 5'd0, 5'd0), 32'h0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    tick();
    @(negedge clk);
    total++; if (cnt !== 8'd1) begin bad++; $display("FAIL cnt_hold: got %0d want 1", cnt); end
    tick();
  endtask

  task automatic test_dump();
    logic [AW-1:0] ea;
    do_reset();
    for (int i = 1; i < NREG; i++) begin
      drive(1'b1, mk(1'b1, AW'(i), 5'd0, 5'd0), XLEN'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL dump_pre_ready: got %b want 1", inst_ready); end
    tick();
    // pending write to x3 that must wait for the dump to finish
    drive(1'b1, mk(1'b1, 5'd3, 5'd0, 5'd3), 32'h0000AAAA, 1'b0);
    for (int b = 0; b < NREG; b++) begin
      ea = AW'(b);
      @(negedge clk);
      total++; if (busy !== 1'b1 || inst_ready !== 1'b0) begin bad++; $display("FAIL dump_busy_b%0d: got busy=%b ready=%b want 1/0", b, busy, inst_ready); end
      total++; if (dump_valid !== 1'b1 || dump_addr !== ea) begin bad++; $display("FAIL dump_addr_b%0d: got valid=%b addr=%0d want 1/%0d", b, dump_valid, dump_addr, b); end
      total++; if (dump_data !== XLEN'(b)) begin bad++; $display("FAIL dump_data_b%0d: got %h want %h", b, dump_data, XLEN'(b)); end
      total++; if (dump_last !== (b == NREG - 1)) begin bad++; $display("FAIL dump_last_b%0d: got %b want %b", b, dump_last, (b == NREG - 1)); end
      if (b == 0) begin
        total++; if (rs1 !== 32'd3) begin bad++; $display("FAIL dump_no_bypass: got %h want 3", rs1); end
      end
      if (b == NREG - 1) begin
        total++; if (cnt !== 8'd31) begin bad++; $display("FAIL dump_cnt_frozen: got %0d want 31", cnt); end
      end
      tick();
    end
    @(negedge clk);
    total++; if (inst_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL dump_post_idle: got ready=%b busy=%b want 1/0", inst_ready, busy); end
    total++; if (rs1 !== 32'h0000AAAA) begin bad++; $display("FAIL dump_pending_byp: got %h want 0000aaaa", rs1); end
    tick();
    drive(1'b0, mk(1'b0, 5'd0, 5'd0, 5'd3), 32'h0, 1'b0);
    @(negedge clk);
    total++; if (rs1 !== 32'h0000AAAA) begin bad++; $display("FAIL dump_pending_wr: got %h want 0000aaaa", rs1); end
    total++; if (cnt !== 8'd32) begin bad++; $display("FAIL dump_pending_cnt: got %0d want 32", cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    int beats;
    // write x2 and request a dump in the same IDLE cycle, then keep dump_req high
    drive(1'b1, mk(1'b1, 5'd2, 5'd0, 5'd0), 32'h00000055, 1'b1);
    @(negedge clk);
    total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept_ready: got %b want 1", inst_ready); end
    tick();
    drive(1'b0, '0, '0, 1'b1);
    for (int b = 0; b < NREG; b++) begin
      @(negedge clk);
      if (b == 2) begin
        total++; if (dump_data !== 32'h55) begin bad++; $display("FAIL b2b_new_value: got %h want 55", dump_data); end
      end
      if (b == 3) begin
        total++; if (dump_data !== 32'h0000AAAA) begin bad++; $display("FAIL b2b_x3: got %h want 0000aaaa", dump_data); end
      end
      tick();
    end
    @(negedge clk);
    total++; if (inst_ready !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap: got ready=%b busy=%b valid=%b want 1/0/0", inst_ready, busy, dump_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    total++; if (busy !== 1'b1 || dump_addr !== 5'd0) begin bad++; $display("FAIL b2b_restart: got busy=%b addr=%0d want 1/0", busy, dump_addr); end
    beats = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      beats++;
      tick();
      @(negedge clk);
    end
    total++; if (beats != NREG) begin bad++; $display("FAIL b2b_length: got %0d beats want %0d", beats, NREG); end
    total++; if (cnt !== 8'd33) begin bad++; $display("FAIL b2b_cnt: got %0d want 33", cnt); end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (10) tick();
    @(negedge clk);
    total++; if (dump_addr !== 5'd10) begin bad++; $display("FAIL rmd_beat10: got %0d want 10", dump_addr); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || dump_valid !== 1'b0) begin bad++; $display("FAIL rmd_abort: got busy=%b valid=%b want 0/0", busy, dump_valid); end
    total++; if (dump_addr !== 5'd0 || dump_data !== 32'h0 || dump_last !== 1'b0) begin bad++; $display("FAIL rmd_outputs: got addr=%0d data=%h last=%b want 0", dump_addr, dump_data, dump_last); end
    tick();
    rst_n = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      drive(1'b0, mk(1'b0, 5'd0, AW'(r), AW'(r)), 32'h0, 1'b0);
      #1;
      total++; if (rs1 !== 32'h0 || rs2 !== 32'h0) begin bad++; $display("FAIL rmd_clear_x%0d: got %h/%h want 0", r, rs1, rs2); end
    end
    total++; if (cnt !== 8'd0) begin bad++; $display("FAIL rmd_cnt: got %0d want 0", cnt); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_cnt_wrap();
    test_dump();
    test_back_to_back();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
